// File: rtl/boot_loader_pkg.sv
// Shared boot loader types and sizing: image geometry, header width and FSM state encoding.
package boot_loader_pkg;

  localparam int unsigned BITS           = 32;
  localparam int unsigned ADDRIW         = 4;
  localparam int unsigned ADDRW          = 4;
  localparam int unsigned BOOT_CNT_W     = 16;
  localparam int unsigned BOOT_HDR_BYTES = 2;
  localparam int unsigned MAX_WORDS      = 2 ** ADDRIW;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    FIN,
    CHK,
    DONE,
    ERR
  } boot_state_t;

endpackage

// File: rtl/boot_loader.sv
// Serial bootloader: header + little-endian words from UART RX into I-MEM writes.
// Optional trailing XOR checksum byte enabled by defining BOOT_CHECKSUM_EN.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned CNT_W = BOOT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_rdy,
  output logic             clr_rx_rdy,
  input  logic             boot_req,
  output logic [BITS-1:0]  wdata_data,
  output logic [ADDRW:0]   wdata_addr,
  output logic             we_boot,
  output logic             bootloading,
  output logic             boot_done,
  output logic             boot_err
);

  localparam int unsigned REM_W = ADDRIW + 1;

  boot_state_t      state, state_nx;
  logic [7:0]       cnt_lo, cnt_lo_nx;
  logic [CNT_W-1:0] cnt_full;
  logic [REM_W-1:0] rem, rem_nx;
  logic [1:0]       idx, idx_nx;
  logic [BITS-1:0]  word, word_nx;
  logic [ADDRW:0]   addr, addr_nx;
  logic             takes_byte;
  logic             accept;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       csum, csum_nx;
`endif

  // The clr term blocks re-accepting the same byte while the UART has not yet dropped rx_rdy.
  always_comb begin
    takes_byte = (state == HDR_LO) || (state == HDR_HI) || (state == DATA) || (state == CHK);
    accept     = takes_byte && rx_rdy && !clr_rx_rdy;
    cnt_full   = CNT_W'({rx_data, cnt_lo});
    state_nx   = state;
    cnt_lo_nx  = cnt_lo;
    rem_nx     = rem;
    idx_nx     = idx;
    word_nx    = word;
    addr_nx    = addr;
    case (state)
      HDR_LO: if (accept) begin
        cnt_lo_nx = rx_data;
        state_nx  = HDR_HI;
      end
      HDR_HI: if (accept) begin
        if (cnt_full == '0) begin
          state_nx = FIN;
        end else if (cnt_full > CNT_W'(MAX_WORDS)) begin
          state_nx = ERR;
        end else begin
          state_nx = DATA;
          idx_nx   = '0;
          addr_nx  = '0;
          rem_nx   = REM_W'(cnt_full);
        end
      end
      DATA: if (accept) begin
        word_nx[{idx, 3'b000} +: 8] = rx_data;
        idx_nx = idx + 2'd1;
        if (idx == 2'd3) state_nx = WRITE;
      end
      WRITE: begin
        addr_nx  = addr + (ADDRW + 1)'(1);
        rem_nx   = rem - REM_W'(1);
        state_nx = (rem == REM_W'(1)) ? FIN : DATA;
      end
`ifdef BOOT_CHECKSUM_EN
      FIN: state_nx = CHK;
      CHK: if (accept) state_nx = (rx_data == csum) ? DONE : ERR;
`else
      FIN: state_nx = DONE;
`endif
      DONE: if (boot_req) state_nx = HDR_LO;
      ERR:  if (boot_req) state_nx = HDR_LO;
      default: state_nx = HDR_LO;
    endcase
  end

`ifdef BOOT_CHECKSUM_EN
  always_comb begin
    csum_nx = csum;
    if (accept && state == HDR_LO)
      csum_nx = rx_data;
    else if (accept && state != CHK)
      csum_nx = csum ^ rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum <= '0;
    else        csum <= csum_nx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HDR_LO;
      cnt_lo      <= '0;
      rem         <= '0;
      idx         <= '0;
      word        <= '0;
      addr        <= '0;
      clr_rx_rdy  <= 1'b0;
      we_boot     <= 1'b0;
      bootloading <= 1'b1;
      boot_done   <= 1'b0;
      boot_err    <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt_lo      <= cnt_lo_nx;
      rem         <= rem_nx;
      idx         <= idx_nx;
      word        <= word_nx;
      addr        <= addr_nx;
      clr_rx_rdy  <= accept;
      // Status outputs are decoded from the next state so they line up with the state register.
      we_boot     <= (state_nx == WRITE);
      bootloading <= (state_nx != DONE);
      boot_done   <= (state_nx == DONE) && (state != DONE);
      boot_err    <= (state_nx == ERR);
    end
  end

  assign wdata_data = word;
  assign wdata_addr = addr;

endmodule
